// File: rtl/rtc_bcd_timekeeper.sv
// BCD HH:MM:SS timekeeper clocked by clk, counting rising edges of a 1 Hz tick.
// Optional alarm compare is built when ALARM_EN is defined.
module rtc_bcd_timekeeper #(
    parameter int MAX_HOUR = 23,
    parameter int RESET_HH = 0,
    parameter int RESET_MM = 0,
    parameter int RESET_SS = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run_en,
    input  logic       set_load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
`ifdef ALARM_EN
    input  logic       alarm_load,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_arm,
    output logic       alarm_out,
`endif
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       day_wrap,
    output logic       set_err
);

    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] bcd_val(logic [7:0] v);
        return {4'd0, v[7:4]} * 8'd10 + {4'd0, v[3:0]};
    endfunction

    function automatic logic [7:0] bcd_inc(logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic sexa_ok(logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
    endfunction

    localparam logic [7:0] MAX_H  = 8'(MAX_HOUR);
    localparam logic [7:0] RST_HH = to_bcd(RESET_HH);
    localparam logic [7:0] RST_MM = to_bcd(RESET_MM);
    localparam logic [7:0] RST_SS = to_bcd(RESET_SS);

    logic       tick_q;
    logic       tick_rise;
    logic       ss_c;
    logic       mm_c;
    logic       hh_top;
    logic       set_ok;
    logic [7:0] ss_n;
    logic [7:0] mm_n;
    logic [7:0] hh_n;

    assign tick_rise = tick_in & ~tick_q;

    assign ss_c   = (ss == 8'h59);
    assign mm_c   = (mm == 8'h59);
    assign hh_top = (bcd_val(hh) == MAX_H);

    assign ss_n = ss_c ? 8'h00 : bcd_inc(ss);
    assign mm_n = !ss_c ? mm : (mm_c ? 8'h00 : bcd_inc(mm));
    assign hh_n = !(ss_c && mm_c) ? hh : (hh_top ? 8'h00 : bcd_inc(hh));

    // Hours tens is bounded by the binary compare against MAX_HOUR.
    assign set_ok = sexa_ok(set_ss) && sexa_ok(set_mm)
                 && (set_hh[3:0] <= 4'd9)
                 && (bcd_val(set_hh) <= MAX_H);

    always_ff @(posedge clk) begin
        tick_q    <= tick_in;
        sec_pulse <= 1'b0;
        day_wrap  <= 1'b0;
        set_err   <= 1'b0;
        if (reset) begin
            tick_q <= 1'b1;
            hh     <= RST_HH;
            mm     <= RST_MM;
            ss     <= RST_SS;
        end else if (set_load) begin
            if (set_ok) begin
                hh <= set_hh;
                mm <= set_mm;
                ss <= set_ss;
            end else begin
                set_err <= 1'b1;
            end
        end else if (tick_rise && run_en) begin
            ss        <= ss_n;
            mm        <= mm_n;
            hh        <= hh_n;
            sec_pulse <= 1'b1;
            day_wrap  <= ss_c && mm_c && hh_top;
        end
    end

`ifdef ALARM_EN
    logic [7:0] al_hh;
    logic [7:0] al_mm;
    logic       al_ok;

    assign al_ok = sexa_ok(alarm_mm)
                && (alarm_hh[3:0] <= 4'd9)
                && (bcd_val(alarm_hh) <= MAX_H);

    always_ff @(posedge clk) begin
        if (reset) begin
            al_hh     <= 8'h00;
            al_mm     <= 8'h00;
            alarm_out <= 1'b0;
        end else begin
            if (alarm_load && al_ok) begin
                al_hh <= alarm_hh;
                al_mm <= alarm_mm;
            end
            alarm_out <= alarm_arm && (hh == al_hh) && (mm == al_mm);
        end
    end
`endif

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Randomized and directed bench for rtc_bcd_timekeeper.
// Reference keeps time as plain seconds-of-day.
module tb_rtc_bcd_timekeeper;

    localparam int MAX_HOUR = 23;
    localparam int DAY      = (MAX_HOUR + 1) * 3600;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       run_en = 1'b0;
    logic       set_load = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_pulse;
    logic       day_wrap;
    logic       set_err;
`ifdef ALARM_EN
    logic       alarm_load = 1'b0;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;
    logic       alarm_arm = 1'b0;
    logic       alarm_out;
`endif

    rtc_bcd_timekeeper #(.MAX_HOUR(MAX_HOUR)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .run_en    (run_en),
        .set_load  (set_load),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
`ifdef ALARM_EN
        .alarm_load(alarm_load),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_arm (alarm_arm),
        .alarm_out (alarm_out),
`endif
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .sec_pulse (sec_pulse),
        .day_wrap  (day_wrap),
        .set_err   (set_err)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;
    bit m_prev = 1'b1;
    int n_pulse = 0;
    int n_wrap = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int dec(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit legal(logic [7:0] h, logic [7:0] m,
                                 logic [7:0] s);
        return h[3:0] <= 9 && m[3:0] <= 9 && s[3:0] <= 9
            && m[7:4] <= 5 && s[7:4] <= 5
            && dec(h) <= MAX_HOUR;
    endfunction

    // One clock: apply inputs, advance the reference, check all outputs.
    task automatic cyc(input bit r, input bit tk, input bit rn,
                       input bit ld, input logic [7:0] h,
                       input logic [7:0] m, input logic [7:0] s);
        bit rise;
        bit e_pulse;
        bit e_wrap;
        bit e_err;
        reset = r; tick_in = tk; run_en = rn; set_load = ld;
        set_hh = h; set_mm = m; set_ss = s;
        e_pulse = 0; e_wrap = 0; e_err = 0;
        rise = tk && !m_prev;
        m_prev = tk;
        if (r) begin
            t = 0;
            m_prev = 1'b1;
        end else if (ld) begin
            if (legal(h, m, s))
                t = dec(h) * 3600 + dec(m) * 60 + dec(s);
            else
                e_err = 1;
        end else if (rise && rn) begin
            t = (t + 1) % DAY;
            e_pulse = 1;
            e_wrap = (t == 0);
        end
        @(posedge clk);
        #1;
        chk("hh", hh, bcd(t / 3600));
        chk("mm", mm, bcd((t / 60) % 60));
        chk("ss", ss, bcd(t % 60));
        chk("sec_pulse", sec_pulse, e_pulse);
        chk("day_wrap", day_wrap, e_wrap);
        chk("set_err", set_err, e_err);
        n_pulse += int'(sec_pulse);
        n_wrap += int'(day_wrap);
    endtask

    task automatic idle(input bit tk, input bit rn);
        cyc(0, tk, rn, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s);
        cyc(0, tick_in, run_en, 1, h, m, s);
    endtask

    initial begin
        bit tk;
        // Reset with tick high at release: no false edge.
        cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
        cyc(1, 1, 1, 0, 8'h00, 8'h00, 8'h00);
        idle(1, 1);
        chk("t1_ss", ss, 8'h00);
        chk("t1_pulse", sec_pulse, 0);
        idle(1, 1);

        n_pulse = 0;
        repeat (3) begin
            idle(0, 1);
            idle(1, 1);
            idle(1, 1);
        end
        chk("t2_ss", ss, 8'h03);
        chk("t2_pulses", n_pulse, 3);

        idle(0, 1);
        load(8'h23, 8'h59, 8'h58);
        n_wrap = 0;
        idle(1, 1);
        chk("t3_ss59", ss, 8'h59);
        chk("t3_nowrap", day_wrap, 0);
        idle(0, 1);
        idle(1, 1);
        chk("t3_hh0", hh, 8'h00);
        chk("t3_wrap", day_wrap, 1);
        idle(1, 1);
        chk("t3_wrap_once", n_wrap, 1);

        load(8'h12, 8'h60, 8'h00);
        chk("t4_err", set_err, 1);
        chk("t4_hold", ss, 8'h00);
        load(8'h24, 8'h00, 8'h00);
        chk("t4_hh24", set_err, 1);
        load(8'h0a, 8'h00, 8'h00);
        chk("t4_nib", set_err, 1);

        idle(0, 1);
        cyc(0, 1, 1, 1, 8'h10, 8'h20, 8'h30);
        chk("t5_ss", ss, 8'h30);
        chk("t5_hh", hh, 8'h10);
        chk("t5_pulse", sec_pulse, 0);

        n_pulse = 0;
        repeat (5) begin
            idle(0, 0);
            idle(1, 0);
        end
        chk("t7_hold", ss, 8'h30);
        idle(1, 1);
        idle(1, 1);
        chk("t7_none", n_pulse, 0);
        idle(0, 1);
        idle(1, 1);
        chk("t7_inc", ss, 8'h31);

`ifdef ALARM_EN
        alarm_load = 1; alarm_hh = 8'h00; alarm_mm = 8'h01; alarm_arm = 1;
        load(8'h00, 8'h00, 8'h59);
        alarm_load = 0;
        idle(0, 1);
        chk("t6_pre", alarm_out, 0);
        idle(1, 1);
        idle(1, 1);
        chk("t6_on", alarm_out, 1);
        alarm_arm = 0;
        idle(1, 1);
        chk("t6_off", alarm_out, 0);
`endif

        tk = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] h;
            logic [7:0] m;
            logic [7:0] s;
            if ($urandom_range(3) == 0)
                tk = ~tk;
            if ($urandom_range(2) == 0) begin
                h = 8'($urandom);
                m = 8'($urandom);
                s = 8'($urandom);
            end else begin
                h = bcd($urandom_range(1) ? 23 : $urandom_range(23));
                m = bcd($urandom_range(1) ? 59 : $urandom_range(59));
                s = bcd($urandom_range(50, 59));
            end
            cyc($urandom_range(499) == 0, tk,
                $urandom_range(7) != 0,
                $urandom_range(39) == 0, h, m, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
